// File: rtl/dram_calib_gate_if.sv
// dram_calib_gate_if
// Handshake-only view of the AXI link that passes through dram_calib_gate.
// AXI payload fields never pass through this interface.
//   slv_* : upstream side (SoC-to-DRAM AXI register stage)
//   mst_* : downstream side (DDR3 memory controller)
//   B and R are monitored only. The gate observes them and never drives them.
// Modports:
//   slave  : the gate's view. It receives the *_i signals and drives the *_o signals.
//   master : the surrounding environment's view, with every direction reversed.
interface dram_calib_gate_if;
    logic slv_aw_valid_i;
    logic slv_aw_ready_o;
    logic mst_aw_valid_o;
    logic mst_aw_ready_i;
    logic slv_w_valid_i;
    logic slv_w_last_i;
    logic slv_w_ready_o;
    logic mst_w_valid_o;
    logic mst_w_ready_i;
    logic mst_b_valid_i;
    logic mst_b_ready_i;
    logic slv_ar_valid_i;
    logic slv_ar_ready_o;
    logic mst_ar_valid_o;
    logic mst_ar_ready_i;
    logic mst_r_valid_i;
    logic mst_r_last_i;
    logic mst_r_ready_i;

    modport slave (
        input  slv_aw_valid_i, mst_aw_ready_i,
        input  slv_w_valid_i, slv_w_last_i, mst_w_ready_i,
        input  mst_b_valid_i, mst_b_ready_i,
        input  slv_ar_valid_i, mst_ar_ready_i,
        input  mst_r_valid_i, mst_r_last_i, mst_r_ready_i,
        output slv_aw_ready_o, mst_aw_valid_o,
        output slv_w_ready_o, mst_w_valid_o,
        output slv_ar_ready_o, mst_ar_valid_o
    );

    modport master (
        output slv_aw_valid_i, mst_aw_ready_i,
        output slv_w_valid_i, slv_w_last_i, mst_w_ready_i,
        output mst_b_valid_i, mst_b_ready_i,
        output slv_ar_valid_i, mst_ar_ready_i,
        output mst_r_valid_i, mst_r_last_i, mst_r_ready_i,
        input  slv_aw_ready_o, mst_aw_valid_o,
        input  slv_w_ready_o, mst_w_valid_o,
        input  slv_ar_ready_o, mst_ar_valid_o
    );
endinterface

// File: rtl/dram_calib_gate.sv
// dram_calib_gate
// This block gates AXI AW/W/AR handshakes between the SoC-to-DRAM register stage and
// the DDR3 controller.
//   - New transactions are held off until the controller reports that calibration is done.
//   - The number of outstanding reads and writes is limited, per direction.
//   - When calibration drops or a flush is requested, in-flight traffic is drained.
// Gating uses only registered state and counters. It never depends on the valid inputs.
// Ports:
//   clk_i, rst_i      : DRAM UI clock and synchronous active-high reset
//   calib_done_i      : calibration complete, from the controller
//   flush_i           : request to drain and return to WAIT_CALIB
//   bus               : handshake signals (dram_calib_gate_if.slave)
//   state_o           : 0=WAIT_CALIB, 1=ACTIVE, 2=DRAIN
//   wr_cnt_o/rd_cnt_o : outstanding writes / reads
//   idle_o            : no outstanding writes, reads or pending W bursts
//   calib_timeout_o   : sticky flag, set after TimeoutCycles-1 cycles in WAIT_CALIB
//   err_unexpected_o  : sticky protocol error flag. The checking logic is built only when
//                       CHESHIRE_DRAM_GATE_CHECK_EN is defined. Otherwise the flag is tied to 0.
module dram_calib_gate #(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned TimeoutCycles  = 1048576,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                calib_done_i,
    input  logic                flush_i,
    dram_calib_gate_if.slave    bus,
    output logic [1:0]          state_o,
    output logic [CntWidth-1:0] wr_cnt_o,
    output logic [CntWidth-1:0] rd_cnt_o,
    output logic                idle_o,
    output logic                calib_timeout_o,
    output logic                err_unexpected_o
);

    localparam int unsigned TmrWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(TimeoutCycles - 1);
    localparam logic [TmrWidth-1:0] TmrArm  = TmrWidth'(TimeoutCycles - 2);

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        ACTIVE     = 2'd1,
        DRAIN      = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntWidth:0]   w_pend_q, w_pend_d;
    logic [TmrWidth-1:0] tmr_q, tmr_d;
    logic                timeout_q, timeout_d;

    logic aw_allow, ar_allow, w_allow;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
    logic wr_dec, rd_dec, wp_dec;

    always_comb begin
        aw_allow = (state_q == ACTIVE) && (wr_cnt_q < MaxCnt);
        ar_allow = (state_q == ACTIVE) && (rd_cnt_q < MaxCnt);
        // W beats keep flowing outside ACTIVE while an accepted AW still needs its data.
        w_allow  = (state_q == ACTIVE) || (w_pend_q != '0);
    end

    assign bus.mst_aw_valid_o = bus.slv_aw_valid_i & aw_allow;
    assign bus.slv_aw_ready_o = bus.mst_aw_ready_i & aw_allow;
    assign bus.mst_w_valid_o  = bus.slv_w_valid_i  & w_allow;
    assign bus.slv_w_ready_o  = bus.mst_w_ready_i  & w_allow;
    assign bus.mst_ar_valid_o = bus.slv_ar_valid_i & ar_allow;
    assign bus.slv_ar_ready_o = bus.mst_ar_ready_i & ar_allow;

    always_comb begin
        aw_hs     = bus.slv_aw_valid_i & bus.mst_aw_ready_i & aw_allow;
        ar_hs     = bus.slv_ar_valid_i & bus.mst_ar_ready_i & ar_allow;
        w_last_hs = bus.slv_w_valid_i & bus.mst_w_ready_i & bus.slv_w_last_i & w_allow;
        b_hs      = bus.mst_b_valid_i & bus.mst_b_ready_i;
        r_last_hs = bus.mst_r_valid_i & bus.mst_r_ready_i & bus.mst_r_last_i;
        // A count of zero is never decremented. A decrement at zero is therefore ignored.
        wr_dec    = b_hs      && (wr_cnt_q != '0);
        rd_dec    = r_last_hs && (rd_cnt_q != '0);
        wp_dec    = w_last_hs && (w_pend_q != '0);
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        w_pend_d = w_pend_q;
        if (aw_hs && !wr_dec)      wr_cnt_d = wr_cnt_q + 1'b1;
        else if (!aw_hs && wr_dec) wr_cnt_d = wr_cnt_q - 1'b1;
        if (ar_hs && !rd_dec)      rd_cnt_d = rd_cnt_q + 1'b1;
        else if (!ar_hs && rd_dec) rd_cnt_d = rd_cnt_q - 1'b1;
        if (aw_hs && !wp_dec)      w_pend_d = w_pend_q + 1'b1;
        else if (!aw_hs && wp_dec) w_pend_d = w_pend_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_CALIB: if (calib_done_i && !flush_i)  state_d = ACTIVE;
            ACTIVE:     if (!calib_done_i || flush_i) state_d = DRAIN;
            DRAIN:      if (wr_cnt_q == '0 && rd_cnt_q == '0 && w_pend_q == '0)
                            state_d = WAIT_CALIB;
            default:    state_d = WAIT_CALIB;
        endcase
    end

    // The timer is held at zero outside WAIT_CALIB, so it starts from zero on every entry.
    // It saturates at TimeoutCycles-1.
    // The flag is armed one count early so that it rises together with the final count.
    always_comb begin
        tmr_d     = '0;
        timeout_d = timeout_q;
        if (state_q == WAIT_CALIB) begin
            tmr_d = (tmr_q == TmrLast) ? tmr_q : tmr_q + 1'b1;
            if (tmr_q == TmrArm) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= WAIT_CALIB;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            w_pend_q  <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            w_pend_q  <= w_pend_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CHESHIRE_DRAM_GATE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (b_hs && wr_cnt_q == '0)                     err_d = 1'b1;
        if (r_last_hs && rd_cnt_q == '0)                err_d = 1'b1;
        if ((aw_hs || ar_hs) && state_q == WAIT_CALIB)  err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_unexpected_o = err_q;
`else
    assign err_unexpected_o = 1'b0;
`endif

    assign state_o         = state_q;
    assign wr_cnt_o        = wr_cnt_q;
    assign rd_cnt_o        = rd_cnt_q;
    assign idle_o          = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_pend_q == '0);
    assign calib_timeout_o = timeout_q;

endmodule
